// File: rtl/aes128_encrypt_sequencer.sv
// Iterative AES-128 encrypt engine: one round per clock on a shared round
// datapath, round keys expanded on the fly, valid/ready on both sides.
module aes128_encrypt_sequencer #(
  parameter int ALLOW_B2B = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ROUND = 3'd1;
  localparam logic [2:0] FINAL = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;

  logic [2:0]   fsmReg;
  logic [127:0] stateReg;
  logic [127:0] keyReg;
  logic [3:0]   roundCntReg;

  // GF(2^8) multiply by x modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box as inverse (a^254, which maps 0 to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for the round key being produced
  function automatic logic [7:0] rconFor(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  logic accept;
  assign in_ready  = !RST && ((fsmReg == IDLE) ||
                     ((ALLOW_B2B != 0) && (fsmReg == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = !RST && (fsmReg == DONE);
  assign busy      = !RST && ((fsmReg == ROUND) || (fsmReg == FINAL));
  assign out_data  = stateReg;
  assign round_cnt = roundCntReg;

  // Key schedule step: the input key on accept, the held round key otherwise
  logic [127:0] keySrc;
  logic [7:0]   rconSel;
  logic [31:0]  keyRot;
  logic [31:0]  keySub;
  logic [31:0]  keyT;
  logic [127:0] keyExp;

  assign keySrc  = (fsmReg == ROUND) ? keyReg : in_key;
  assign rconSel = (fsmReg == ROUND) ? rconFor(4'(roundCntReg + 4'd1)) : 8'h01;
  assign keyRot  = {keySrc[23:0], keySrc[31:24]};
  assign keyT    = keySub ^ {rconSel, 24'h0};
  assign keyExp[127:96] = keySrc[127:96] ^ keyT;
  assign keyExp[95:64]  = keySrc[95:64]  ^ keyExp[127:96];
  assign keyExp[63:32]  = keySrc[63:32]  ^ keyExp[95:64];
  assign keyExp[31:0]   = keySrc[31:0]   ^ keyExp[63:32];

  // Shared round datapath: SubBytes, ShiftRows, MixColumns
  logic [7:0]   subB   [16];
  logic [7:0]   shiftB [16];
  logic [127:0] shiftVec;
  logic [127:0] mixVec;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gKeySub
      assign keySub[gi*8 +: 8] = sbox(keyRot[gi*8 +: 8]);
    end
    for (gi = 0; gi < 16; gi++) begin : gSubShift
      // byte gi sits at column gi/4, row gi%4; row r rotates left by r
      assign subB[gi]   = sbox(stateReg[127-8*gi -: 8]);
      assign shiftB[gi] = subB[(((gi / 4) + (gi % 4)) % 4) * 4 + (gi % 4)];
      assign shiftVec[127-8*gi -: 8] = shiftB[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : gMix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = shiftB[gi*4];
      assign a1 = shiftB[gi*4+1];
      assign a2 = shiftB[gi*4+2];
      assign a3 = shiftB[gi*4+3];
      assign mixVec[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mixVec[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mixVec[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mixVec[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  // Sequencer: load on accept, nine full rounds, final round, hold result
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsmReg      <= IDLE;
      stateReg    <= '0;
      keyReg      <= '0;
      roundCntReg <= '0;
    end else begin
      case (fsmReg)
        IDLE, DONE: begin
          if (accept) begin
            stateReg    <= in_data ^ in_key;
            keyReg      <= keyExp;
            roundCntReg <= 4'd1;
            fsmReg      <= ROUND;
          end else if (fsmReg == DONE && out_ready) begin
            fsmReg <= IDLE;
          end
        end
        ROUND: begin
          stateReg <= mixVec ^ keyReg;
          keyReg   <= keyExp;
          if (roundCntReg == 4'd9) begin
            roundCntReg <= 4'd10;
            fsmReg      <= FINAL;
          end else begin
            roundCntReg <= roundCntReg + 4'd1;
          end
        end
        FINAL: begin
          stateReg    <= shiftVec ^ keyReg;
          roundCntReg <= 4'd0;
          fsmReg      <= DONE;
        end
        default: begin
          roundCntReg <= 4'd0;
          fsmReg      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_sequencer.sv
// Self-checking bench: FIPS-197 vectors, latency/throughput, backpressure,
// mid-run reset, ignored input while busy, and random blocks against a
// table-driven AES reference model.
module tb_aes128_encrypt_sequencer;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         inValid, inReady, outValid, outReady, busy;
  logic [127:0] inKey, inData, outData;
  logic [3:0]   roundCnt;

  logic         nbInValid, nbInReady, nbOutValid, nbOutReady, nbBusy;
  logic [127:0] nbKey, nbData, nbOutData;
  logic [3:0]   nbRoundCnt;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] sboxTab [256];

  always #5 CLK = ~CLK;

  aes128_encrypt_sequencer #(.ALLOW_B2B(1)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(inValid), .in_ready(inReady), .in_key(inKey), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .busy(busy), .round_cnt(roundCnt)
  );

  aes128_encrypt_sequencer #(.ALLOW_B2B(0)) dutNoB2b (
    .CLK(CLK), .RST(RST),
    .in_valid(nbInValid), .in_ready(nbInReady), .in_key(nbKey), .in_data(nbData),
    .out_valid(nbOutValid), .out_ready(nbOutReady), .out_data(nbOutData),
    .busy(nbBusy), .round_cnt(nbRoundCnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mulc(input int c, input logic [7:0] b);
    if (c == 2) return xt(b);
    if (c == 3) return xt(b) ^ b;
    return b;
  endfunction

  // S-box table built by walking generator 3 and its inverse in lockstep
  task automatic buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sboxTab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxTab[0] = 8'h63;
  endtask

  // Reference AES-128: full 44-word key schedule, then byte-array rounds
  function automatic logic [127:0] aesRef(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   acc;
    logic [127:0] res;
    int coef [4];
    coef[0] = 2; coef[1] = 3; coef[2] = 1; coef[3] = 1;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sboxTab[tmp[31:24]], sboxTab[tmp[23:16]], sboxTab[tmp[15:8]], sboxTab[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sboxTab[s[(((i/4) + (i%4)) % 4) * 4 + (i%4)]];
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) begin
          if (r < 10) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ mulc(coef[(k - row + 4) % 4], t[c*4+k]);
          end else begin
            acc = t[c*4+row];
          end
          s[c*4+row] = acc ^ w[4*r+c][31-8*row -: 8];
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // One block: accept, step through rounds, check result, hold, consume
  task automatic runBlock(input string tag, input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] expCt, input bit disturb, input int hold);
    int lat;
    inKey = key; inData = pt; inValid = 1'b1; outReady = 1'b0;
    #1;
    chk({tag, " in_ready idle"}, 128'(inReady), 128'(1));
    @(negedge CLK);
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 30) begin
      chk({tag, " round_cnt"}, 128'(roundCnt), 128'(lat + 1));
      if (disturb) begin
        inValid = 1'($urandom_range(0, 1));
        inKey   = {$urandom, $urandom, $urandom, $urandom};
        inData  = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk({tag, " in_ready busy"}, 128'(inReady), 128'(0));
      end
      @(negedge CLK);
      lat++;
    end
    chk({tag, " latency"}, 128'(lat), 128'(10));
    chk({tag, " out_data"}, outData, expCt);
    chk({tag, " done busy/round_cnt"}, 128'({busy, roundCnt}), 128'(0));
    inValid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      inValid = 1'b1;
      inKey   = {$urandom, $urandom, $urandom, $urandom};
      inData  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
      chk({tag, " hold valid/in_ready"}, 128'({outValid, inReady}), 128'(2'b10));
      chk({tag, " hold out_data"}, outData, expCt);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(negedge CLK);
    outReady = 1'b0;
    chk({tag, " consumed out_valid"}, 128'(outValid), 128'(0));
    chk({tag, " back to idle in_ready"}, 128'(inReady), 128'(1));
    $display("block %s key=%h pt=%h ct=%h latency=%0d", tag, key, pt, outData, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int tA1, tA2, tB1, tB2, w;
    bit sawValid;
    logic [127:0] rk, rp;

    buildSbox();
    RST = 1'b1; inValid = 1'b0; inKey = '0; inData = '0; outReady = 1'b0;
    nbInValid = 1'b0; nbKey = '0; nbData = '0; nbOutReady = 1'b1;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("reset in_ready", 128'(inReady), 128'(0));
    chk("reset out_valid/busy/round_cnt", 128'({outValid, busy, roundCnt}), 128'(0));
    chk("reset out_data", outData, 128'(0));
    RST = 1'b0;
    #1;
    chk("post-reset in_ready", 128'(inReady), 128'(1));
    @(negedge CLK);

    // Known vectors, backpressure on the second one, ignored input while busy
    runBlock("C1", K1, P1, C1, 1'b0, 0);
    runBlock("AppB-backpressure", K2, P2, C2, 1'b0, 20);
    runBlock("C1-busy-ignored", K1, P1, C1, 1'b1, 0);

    // Back-to-back: B2B instance vs return-to-idle instance
    inKey = K1; inData = P1; inValid = 1'b1; outReady = 1'b1;
    nbKey = K1; nbData = P1; nbInValid = 1'b1; nbOutReady = 1'b1;
    @(negedge CLK);
    inKey = K2; inData = P2; nbKey = K2; nbData = P2;
    tA1 = -1; tA2 = -1; tB1 = -1; tB2 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (outValid) begin
        if (tA1 < 0) begin
          tA1 = c;
          chk("b2b first ct", outData, C1);
          chk("b2b accept with consume", 128'({inValid, inReady}), 128'(2'b11));
        end else if (tA2 < 0) begin
          tA2 = c;
          chk("b2b second ct", outData, C2);
        end
      end
      if (nbOutValid) begin
        if (tB1 < 0) begin
          tB1 = c;
          chk("nob2b first ct", nbOutData, C1);
        end else if (tB2 < 0) begin
          tB2 = c;
          chk("nob2b second ct", nbOutData, C2);
        end
      end
      if (tA1 >= 0 && busy) inValid = 1'b0;
      if (tB1 >= 0 && nbBusy) nbInValid = 1'b0;
    end
    chk("b2b first latency", 128'(tA1), 128'(10));
    chk("b2b result gap", 128'(tA2 - tA1), 128'(11));
    chk("nob2b result gap", 128'(tB2 - tB1), 128'(12));
    chk("nob2b idle state", 128'({nbInReady, nbOutValid, nbBusy, nbRoundCnt}), 128'(7'b1000000));
    $display("b2b results at cycles %0d,%0d; no-b2b at %0d,%0d", tA1, tA2, tB1, tB2);
    inValid = 1'b0; outReady = 1'b0;
    @(negedge CLK);

    // Reset in the middle of round 5
    inKey = K1; inData = P1; inValid = 1'b1;
    @(negedge CLK);
    inValid = 1'b0;
    w = 0;
    while (roundCnt != 4'd5 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("midrst reached round 5", 128'(roundCnt), 128'(5));
    RST = 1'b1;
    #1;
    chk("midrst in_ready during reset", 128'(inReady), 128'(0));
    @(negedge CLK);
    chk("midrst busy/out_valid/round_cnt", 128'({busy, outValid, roundCnt}), 128'(0));
    chk("midrst state", outData, 128'(0));
    chk("midrst key", dut.keyReg, 128'(0));
    RST = 1'b0;
    #1;
    chk("midrst in_ready after release", 128'(inReady), 128'(1));
    sawValid = 1'b0;
    repeat (15) begin
      @(negedge CLK);
      if (outValid) sawValid = 1'b1;
    end
    chk("midrst no out_valid", 128'(sawValid), 128'(0));
    $display("mid-run reset applied at round_cnt=5");
    runBlock("C1-after-reset", K1, P1, C1, 1'b0, 0);

    // Random blocks against the reference model
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      runBlock($sformatf("rand%0d", n), rk, rp, aesRef(rk, rp), n[0], 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_sequencer.md
Name: aes128_encrypt_sequencer

Overview:
Iterative AES-128 encryption controller. It accepts one plaintext/key pair over a valid/ready handshake and runs the initial AddRoundKey, nine full rounds and the final round on one shared round datapath, one round per CLK cycle. Round keys are expanded on the fly, one per cycle. The ciphertext is held behind a valid/ready output handshake. It is the top-level encrypt engine that drives the team's encrypt_round and encrypt_final_round datapath blocks.

Parameters:
ALLOW_B2B, 1, 1 = a new block may be accepted in the same cycle the previous result is consumed; 0 = must return to IDLE first.

Ports:
CLK  in  1  clock, all state updates on posedge.
RST  in  1  synchronous active-high reset.
in_valid  in  1  plaintext/key offered.
in_ready  out  1  block can accept input.
in_key  in  128  cipher key; FIPS-197 byte 0 in [127:120].
in_data  in  128  plaintext; same byte order.
out_valid  out  1  ciphertext available.
out_ready  in  1  consumer accepts ciphertext.
out_data  out  128  ciphertext.
busy  out  1  high in ROUND or FINAL.
round_cnt  out  4  current round number, 0 in IDLE/DONE.

Behaviour:
- Registers: fsm, state_reg[127:0], key_reg[127:0], round_cnt[3:0]. On RST, all of these clear to 0 and fsm goes to IDLE; out_valid=0, busy=0, in_ready=0 while RST is high.
- Key step expand(k, rc): split k into words k0..k3, with k0=[127:96].
  - t = SubWord(RotWord(k3)) ^ {rc,24'h0}.
  - n0=k0^t, n1=k1^n0, n2=k2^n1, n3=k3^n2.
  - Implemented with 4 SubWord byte instances.
- Rcon by the round being produced: 1:01, 2:02, 3:04, 4:08, 5:10, 6:20, 7:40, 8:80, 9:1B, 10:36.
- in_ready = (fsm==IDLE) | (ALLOW_B2B & fsm==DONE & out_ready), gated by !RST.
- Accept = in_valid & in_ready. On accept:
  - state_reg <= in_data ^ in_key.
  - key_reg <= expand(in_key, 01).
  - round_cnt <= 1; fsm <= ROUND.
  - in_key/in_data are sampled only in this cycle.
- ROUND (round_cnt r = 1..9), each cycle:
  - state_reg <= encrypt_round(state_reg, key_reg).
  - key_reg <= expand(key_reg, rcon[r+1]).
  - If r==9: round_cnt <= 10 and fsm <= FINAL; otherwise round_cnt <= r+1.
- FINAL: state_reg <= encrypt_final_round(state_reg, key_reg); round_cnt <= 0; fsm <= DONE.
- DONE:
  - out_valid=1 and out_data=state_reg.
  - out_data must hold stable while out_valid & !out_ready.
  - On out_ready: if a simultaneous accept occurs (ALLOW_B2B=1), go to ROUND with the new block. Otherwise go to IDLE.
- Latency: accept at edge T gives out_valid high after edge T+10, i.e. 10 cycles.
  - With an always-ready consumer and ALLOW_B2B=1, throughput is one block per 11 cycles.
- out_valid and busy are decoded from the registered fsm only (no combinational path from in_valid).
- in_valid while busy is ignored; in_ready stays 0 and no input is sampled.
- RST asserted mid-operation: the block aborts at the next edge. There is no out_valid for the aborted block, and in_ready rises the cycle after RST falls.
- out_ready while out_valid=0 has no effect.
- Unused encodings of fsm recover to IDLE.

Test Plan:
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid rises exactly 10 cycles after accept; round_cnt steps 1..10.
- FIPS-197 App. B vector: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data and out_valid stay constant and in_ready=0. Then pulse out_ready for 1 cycle -> out_valid drops the next cycle.
- Back-to-back with ALLOW_B2B=1: C.1 then App. B with in_valid held and out_ready=1 -> the second accept happens in the same cycle the first result is consumed, and the two results arrive 11 cycles apart. With ALLOW_B2B=0 the gap is 12 cycles.
- Reset mid-run: pulse RST for one cycle at round_cnt=5 -> busy=0, out_valid never asserts, all registers read 0. A fresh C.1 run afterwards gives the correct ciphertext.
- Input ignored while busy: change in_data/in_key and toggle in_valid during ROUND -> in_ready=0 and the result still equals the original vector.
